parking_sensor_gen: RTL and testbench

Stimulus generator for the parking-lot entrance: converts high-level commands (car in, car out, pedestrian in either direction) into the two photo-sensor waveforms `A`/`B` that the entrance decoder FSM consumes. It drives the inverse of the protocol that FSM decodes: entry is 10→11→01→00, exit is 01→11→10→00, and a pedestrian breaks a single beam only. It sits on the FPGA demo and bench side, driven by push-buttons or a testbench, and keeps a shadow occupancy count to cross-check the decoder's counter.

---
 rtl/parking_pkg.sv | 34 +++
 rtl/parking_sensor_gen_phase_timer.sv | 28 ++
 rtl/parking_sensor_gen.sv | 129 ++++++++++++
 tb/tb_parking_sensor_gen.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the parking-lot entrance: decoder state codes,
// stimulus-generator phase codes and entrance command codes.
package parking_pkg;

    typedef enum logic [2:0] {
        s0 = 3'd0,
        s1 = 3'd1,
        s2 = 3'd2,
        s3 = 3'd3,
        s4 = 3'd4,
        s5 = 3'd5,
        s6 = 3'd6
    } dec_state_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3,
        GAP  = 3'd4
    } gen_state_t;

    typedef enum logic [1:0] {
        CMD_CAR_IN  = 2'b00,
        CMD_CAR_OUT = 2'b01,
        CMD_PED_A   = 2'b10,
        CMD_PED_B   = 2'b11
    } cmd_t;

    function automatic logic is_car(cmd_t c);
        return (c == CMD_CAR_IN) || (c == CMD_CAR_OUT);
    endfunction

endpackage

// File: rtl/parking_sensor_gen_phase_timer.sv
// Phase duration timer: reloads to HOLD_CYCLES-1 on load and flags expire
// on the last cycle of the phase.
module phase_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic CLK,
    input  logic reset,
    input  logic load,
    output logic expire
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge CLK) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(HOLD_CYCLES - 1);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/parking_sensor_gen.sv
// Photo-sensor stimulus generator: turns car/pedestrian commands into the
// A/B beam waveforms and tracks a shadow occupancy count.
module parking_sensor_gen
    import parking_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CAPACITY    = 7
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    output logic       A,
    output logic       B,
    output logic       done,
    output logic [3:0] ocupacao,
    output logic [2:0] estado
);

    gen_state_t state;
    gen_state_t state_next;
    cmd_t       cmd_q;
    cmd_t       cmd_eff;
    logic       accept;
    logic       load;
    logic       expire;
    logic       finish;
    logic [1:0] ab_next;

    function automatic logic [1:0] phase_ab(gen_state_t s, cmd_t c);
        logic [1:0] ab;
        ab = 2'b00;
        case (s)
            PH1:     ab = (c == CMD_CAR_IN || c == CMD_PED_A) ? 2'b10 : 2'b01;
            PH2:     ab = 2'b11;
            PH3:     ab = (c == CMD_CAR_IN) ? 2'b01 : 2'b10;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

    function automatic logic [3:0] occ_update(logic [3:0] occ, cmd_t c);
        logic [3:0] res;
        res = occ;
        if (c == CMD_CAR_IN && occ < 4'(CAPACITY)) begin
            res = occ + 4'd1;
        end else if (c == CMD_CAR_OUT && occ != 4'd0) begin
            res = occ - 4'd1;
        end
        return res;
    endfunction

    phase_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
        .CLK   (CLK),
        .reset (reset),
        .load  (load),
        .expire(expire)
    );

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_ready && cmd_valid;
    assign finish    = (state == GAP) && expire;
    // The phase being entered decodes against the command just accepted.
    assign cmd_eff   = accept ? cmd_t'(cmd) : cmd_q;
    assign ab_next   = phase_ab(state_next, cmd_eff);
    assign estado    = state;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = PH1;
                    load       = 1'b1;
                end
            end
            PH1: begin
                if (expire) begin
                    state_next = is_car(cmd_q) ? PH2 : GAP;
                    load       = 1'b1;
                end
            end
            PH2: begin
                if (expire) begin
                    state_next = PH3;
                    load       = 1'b1;
                end
            end
            PH3: begin
                if (expire) begin
                    state_next = GAP;
                    load       = 1'b1;
                end
            end
            GAP: begin
                if (expire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= IDLE;
            cmd_q    <= CMD_CAR_IN;
            A        <= 1'b0;
            B        <= 1'b0;
            done     <= 1'b0;
            ocupacao <= 4'd0;
        end else begin
            state    <= state_next;
            {A, B}   <= ab_next;
            done     <= finish;
            if (accept) begin
                cmd_q <= cmd_t'(cmd);
            end
            if (finish) begin
                ocupacao <= occ_update(ocupacao, cmd_q);
            end
        end
    end

endmodule

// File: tb/tb_parking_sensor_gen.sv
// Directed bench for parking_sensor_gen with HOLD_CYCLES=2, CAPACITY=3.
module tb_parking_sensor_gen;

    logic       CLK;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic       A;
    logic       B;
    logic       done;
    logic [3:0] ocupacao;
    logic [2:0] estado;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    parking_sensor_gen #(
        .HOLD_CYCLES(2),
        .CAPACITY   (3)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd      (cmd),
        .cmd_ready(cmd_ready),
        .A        (A),
        .B        (B),
        .done     (done),
        .ocupacao (ocupacao),
        .estado   (estado)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command and follow it to the done cycle; seq lists {A,B} per cycle.
    task automatic run_seq(input string tag, input logic [1:0] c, input logic [15:0] seq,
                           input int n, input logic [3:0] occ_exp);
        cmd       = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            check({tag, " ab"}, 8'({A, B}), 8'(seq[15-2*i -: 2]));
            check({tag, " busy"}, 8'(cmd_ready), 8'd0);
            tick();
        end
        check({tag, " done"}, 8'(done), 8'd1);
        check({tag, " ready"}, 8'(cmd_ready), 8'd1);
        check({tag, " occ"}, 8'(ocupacao), 8'(occ_exp));
        tick();
        check({tag, " done_low"}, 8'(done), 8'd0);
    endtask

    initial begin
        logic [15:0] car_in_seq;
        car_in_seq = 16'b10_10_11_11_01_01_00_00;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd       = 2'b00;
        tick();
        tick();
        reset = 1'b0;

        check("rst A", 8'(A), 8'd0);
        check("rst B", 8'(B), 8'd0);
        check("rst done", 8'(done), 8'd0);
        check("rst occ", 8'(ocupacao), 8'd0);
        check("rst estado", 8'(estado), 8'd0);
        check("rst ready", 8'(cmd_ready), 8'd1);

        run_seq("car_in", 2'b00, car_in_seq, 8, 4'd1);
        run_seq("car_out", 2'b01, 16'b01_01_11_11_10_10_00_00, 8, 4'd0);
        run_seq("ped_a", 2'b10, 16'b10_10_00_00_00_00_00_00, 4, 4'd0);
        run_seq("ped_b", 2'b11, 16'b01_01_00_00_00_00_00_00, 4, 4'd0);

        // Back-to-back car entries with cmd_valid held high.
        cmd       = 2'b00;
        cmd_valid = 1'b1;
        tick();
        for (int j = 1; j <= 4; j++) begin
            for (int i = 0; i < 8; i++) begin
                check("b2b ab", 8'({A, B}), 8'(car_in_seq[15-2*i -: 2]));
                if (i == 0) check("b2b estado", 8'(estado), 8'd1);
                tick();
            end
            check("b2b done", 8'(done), 8'd1);
            check("b2b occ", 8'(ocupacao), (j < 3) ? 8'(j) : 8'd3);
            if (j == 4) cmd_valid = 1'b0;
            tick();
        end
        check("b2b idle", 8'(estado), 8'd0);
        check("b2b done_low", 8'(done), 8'd0);

        // Reset in PH2 of a car entry, then reset together with cmd_valid.
        cmd       = 2'b00;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("mid ph2 estado", 8'(estado), 8'd2);
        check("mid ph2 ab", 8'({A, B}), 8'b11);
        reset = 1'b1;
        tick();
        check("mid rst ab", 8'({A, B}), 8'b00);
        check("mid rst estado", 8'(estado), 8'd0);
        check("mid rst done", 8'(done), 8'd0);
        check("mid rst occ", 8'(ocupacao), 8'd0);
        cmd_valid = 1'b1;
        tick();
        check("rst+valid estado", 8'(estado), 8'd0);
        check("rst+valid ab", 8'({A, B}), 8'b00);
        reset     = 1'b0;
        cmd_valid = 1'b0;
        tick();
        check("post rst ready", 8'(cmd_ready), 8'd1);
        check("post rst done", 8'(done), 8'd0);

        run_seq("exit_at_0", 2'b01, 16'b01_01_11_11_10_10_00_00, 8, 4'd0);

        // cmd_valid pulsed during GAP of a pedestrian sequence.
        cmd       = 2'b10;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("gap ph1 ab", 8'({A, B}), 8'b10);
        tick();
        tick();
        check("gap estado", 8'(estado), 8'd4);
        check("gap ready", 8'(cmd_ready), 8'd0);
        cmd       = 2'b00;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("gap ready2", 8'(cmd_ready), 8'd0);
        check("gap done_early", 8'(done), 8'd0);
        tick();
        check("gap done", 8'(done), 8'd1);
        check("gap occ", 8'(ocupacao), 8'd0);
        tick();
        check("gap no_seq estado", 8'(estado), 8'd0);
        check("gap no_seq ab", 8'({A, B}), 8'b00);
        check("gap no_seq done", 8'(done), 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
